// File: rtl/inst_mem_pipe.sv
// Instruction memory with a loader phase and a one-stage registered fetch port.
// Words are written by the loader in LOAD; fetches are served in RUN with stall/flush control.
module inst_mem_pipe #(
  parameter int unsigned ADDR_W    = 8,
  parameter bit          BOOT_LOAD = 1'b1,
  parameter logic [31:0] NOP       = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  input  logic              stall,
  input  logic              flush,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              addr_err,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_done,
  output logic              loading,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic {LOAD, RUN} state_t;

  state_t state, state_nxt;

  logic [31:0]       mem [0:(1 << ADDR_W) - 1];
  logic [ADDR_W-1:0] word_idx;
  logic [30:0]       hi_bits;
  logic              bad_addr;
  logic              accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT_LOAD ? LOAD : RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    unique case (state)
      LOAD: if (ld_done) state_nxt = RUN;
      RUN:  req_ready = ~stall & ~flush;
      default: state_nxt = state;
    endcase
  end

  assign loading  = (state == LOAD);
  assign accept   = req_valid & req_ready;
  assign word_idx = req_addr[ADDR_W+1:2];
  // Bit 31 is a mode bit and takes no part in the range check.
  assign hi_bits  = req_addr[30:0] >> (ADDR_W + 2);
  assign bad_addr = (req_addr[1:0] != 2'b00) || (hi_bits != '0);

  // No reset on the array: contents survive reset, and a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && loading && ld_we) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_valid <= 1'b0;
      inst       <= NOP;
      inst_pc    <= '0;
      addr_err   <= 1'b0;
      fetch_cnt  <= '0;
    end else if (flush) begin
      inst_valid <= 1'b0;
      inst       <= NOP;
      addr_err   <= 1'b0;
    end else if (stall) begin
      inst_valid <= inst_valid;
    end else if (accept) begin
      inst_valid <= 1'b1;
      inst_pc    <= req_addr;
      addr_err   <= bad_addr;
      inst       <= bad_addr ? NOP : mem[word_idx];
      fetch_cnt  <= fetch_cnt + 32'd1;
    end else begin
      inst_valid <= 1'b0;
      inst       <= NOP;
      addr_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Directed bench for inst_mem_pipe: load, fetch, stall/flush, address errors, reset retention, counter wrap.
module tb_inst_mem_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        stall;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        addr_err;
  logic        ld_we;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        loading;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_mem_pipe #(.ADDR_W(8), .BOOT_LOAD(1'b1), .NOP(32'h00000000)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .stall(stall), .flush(flush), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .addr_err(addr_err), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done), .loading(loading),
    .fetch_cnt(fetch_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (loading !== 1'b1)        begin errors++; $display("FAIL rst_loading got %b exp 1", loading); end
    checks++; if (inst_valid !== 1'b0)     begin errors++; $display("FAIL rst_valid got %b exp 0", inst_valid); end
    checks++; if (inst !== 32'h0)          begin errors++; $display("FAIL rst_inst got %h exp 0", inst); end
    checks++; if (inst_pc !== 32'h0)       begin errors++; $display("FAIL rst_pc got %h exp 0", inst_pc); end
    checks++; if (addr_err !== 1'b0)       begin errors++; $display("FAIL rst_err got %b exp 0", addr_err); end
    checks++; if (fetch_cnt !== 32'h0)     begin errors++; $display("FAIL rst_cnt got %h exp 0", fetch_cnt); end
    checks++; if (req_ready !== 1'b0)      begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
  endtask

  task automatic test_reset_midload();
    reset = 1'b0;
    ld_we = 1'b1; ld_addr = 8'd5; ld_data = 32'hDEADBEEF;
    step();
    ld_we = 1'b0;
    step();
    reset = 1'b1;
    #1;
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL midload_loading got %b exp 1", loading); end
    // A write presented while reset is high must be dropped.
    ld_we = 1'b1; ld_addr = 8'd5; ld_data = 32'h11111111;
    step();
    ld_we = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL midload_restart got %b exp 1", loading); end
  endtask

  task automatic test_load_gating();
    req_valid = 1'b1; req_addr = 32'h40;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL gate_ready got %b exp 0", req_ready); end
    step();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL gate_valid got %b exp 0", inst_valid); end
    checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL gate_cnt got %h exp 0", fetch_cnt); end
    req_valid = 1'b0;
    ld_we = 1'b1; ld_addr = 8'd16; ld_data = 32'h0C00000F;
    step();
    ld_addr = 8'd17; ld_data = 32'h3C0D4000; ld_done = 1'b1;
    #1;
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL gate_still_load got %b exp 1", loading); end
    step();
    ld_we = 1'b0; ld_done = 1'b0;
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL gate_run got %b exp 0", loading); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL gate_run_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_fetch();
    req_valid = 1'b1; req_addr = 32'h40;
    step();
    checks++; if (inst_valid !== 1'b1)      begin errors++; $display("FAIL f40_valid got %b exp 1", inst_valid); end
    checks++; if (inst !== 32'h0C00000F)    begin errors++; $display("FAIL f40_inst got %h exp 0c00000f", inst); end
    checks++; if (inst_pc !== 32'h40)       begin errors++; $display("FAIL f40_pc got %h exp 40", inst_pc); end
    checks++; if (addr_err !== 1'b0)        begin errors++; $display("FAIL f40_err got %b exp 0", addr_err); end
    req_addr = 32'h44;
    step();
    checks++; if (inst !== 32'h3C0D4000)    begin errors++; $display("FAIL f44_inst got %h exp 3c0d4000", inst); end
    checks++; if (inst_pc !== 32'h44)       begin errors++; $display("FAIL f44_pc got %h exp 44", inst_pc); end
    checks++; if (fetch_cnt !== 32'd2)      begin errors++; $display("FAIL f44_cnt got %0d exp 2", fetch_cnt); end
  endtask

  task automatic test_stall_flush();
    req_addr = 32'h48; stall = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", req_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h3C0D4000 || inst_pc !== 32'h44 || addr_err !== 1'b0 || fetch_cnt !== 32'd2) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b i=%h pc=%h e=%b c=%0d exp v=1 i=3c0d4000 pc=44 e=0 c=2",
                 i, inst_valid, inst, inst_pc, addr_err, fetch_cnt);
      end
    end
    flush = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", req_ready); end
    step();
    checks++; if (inst_valid !== 1'b0)  begin errors++; $display("FAIL flush_valid got %b exp 0", inst_valid); end
    checks++; if (inst !== 32'h0)       begin errors++; $display("FAIL flush_inst got %h exp 0", inst); end
    checks++; if (inst_pc !== 32'h44)   begin errors++; $display("FAIL flush_pc got %h exp 44", inst_pc); end
    checks++; if (fetch_cnt !== 32'd2)  begin errors++; $display("FAIL flush_cnt got %0d exp 2", fetch_cnt); end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_addr_err();
    req_valid = 1'b1; req_addr = 32'h42;
    step();
    checks++; if (addr_err !== 1'b1 || inst !== 32'h0 || inst_valid !== 1'b1)
      begin errors++; $display("FAIL err42 got e=%b i=%h v=%b exp e=1 i=0 v=1", addr_err, inst, inst_valid); end
    checks++; if (inst_pc !== 32'h42) begin errors++; $display("FAIL err42_pc got %h exp 42", inst_pc); end
    req_addr = 32'h400;
    step();
    checks++; if (addr_err !== 1'b1 || inst !== 32'h0)
      begin errors++; $display("FAIL err400 got e=%b i=%h exp e=1 i=0", addr_err, inst); end
    req_addr = 32'h3FC;
    step();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL top_word_err got %b exp 0", addr_err); end
    req_addr = 32'h80000040;
    step();
    checks++; if (addr_err !== 1'b0 || inst !== 32'h0C00000F)
      begin errors++; $display("FAIL kseg got e=%b i=%h exp e=0 i=0c00000f", addr_err, inst); end
    req_addr = 32'h14;
    step();
    checks++; if (inst !== 32'hDEADBEEF) begin errors++; $display("FAIL retain5 got %h exp deadbeef", inst); end
    checks++; if (fetch_cnt !== 32'd7)   begin errors++; $display("FAIL err_cnt got %0d exp 7", fetch_cnt); end
    req_valid = 1'b0;
    step();
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || addr_err !== 1'b0)
      begin errors++; $display("FAIL idle got v=%b i=%h e=%b exp v=0 i=0 e=0", inst_valid, inst, addr_err); end
  endtask

  task automatic test_wrap();
    force dut.fetch_cnt = 32'hFFFFFFFF;
    #1;
    release dut.fetch_cnt;
    req_valid = 1'b1; req_addr = 32'h40;
    step();
    req_valid = 1'b0;
    checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL wrap got %h exp 0", fetch_cnt); end
  endtask

  task automatic test_reset_in_run();
    reset = 1'b1;
    #1;
    checks++; if (loading !== 1'b1 || inst_valid !== 1'b0 || fetch_cnt !== 32'h0)
      begin errors++; $display("FAIL run_rst got l=%b v=%b c=%h exp l=1 v=0 c=0", loading, inst_valid, fetch_cnt); end
    step();
    reset = 1'b0;
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    req_valid = 1'b1; req_addr = 32'h44;
    step();
    req_valid = 1'b0;
    checks++; if (inst !== 32'h3C0D4000) begin errors++; $display("FAIL persist got %h exp 3c0d4000", inst); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; stall = 1'b0; flush = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    step();
    step();
    test_reset();
    test_reset_midload();
    test_load_gating();
    test_fetch();
    test_stall_flush();
    test_addr_err();
    test_wrap();
    test_reset_in_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
